// File: rtl/regfile_pkg.sv
// Shared defaults and entry layout for the regfile writeback buffer.
package regfile_pkg;

  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned RF_DATA_W = 32;

  // One pending regfile write at the default widths.
  typedef struct packed {
    logic                 valid;
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_fwd_match.sv
// Priority search of pending writes for one read port.
// The newest valid entry with a matching address supplies the data.
module regfile_fwd_match #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned PTR_W      = $clog2(DEPTH),
  parameter bit          DISCARD_R0 = 1'b1
) (
  input  logic [DEPTH-1:0]             valid_i,
  input  logic [DEPTH-1:0][ADDR_W-1:0] addr_i,
  input  logic [DEPTH-1:0][DATA_W-1:0] data_i,
  input  logic [PTR_W-1:0]             tail_i,
  input  logic [ADDR_W-1:0]            rd_addr_i,
  output logic                         hit_o,
  output logic [DATA_W-1:0]            data_o
);

  logic [PTR_W-1:0] idx;
  logic             found;
  logic             addr_ok;

  assign addr_ok = !(DISCARD_R0 && (rd_addr_i == '0));

  // Walk from tail-1 backwards; slots outside the occupied range are invalid,
  // so the first match encountered is the newest.
  always_comb begin
    found  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = tail_i - PTR_W'(k + 1);
      if (!found && addr_ok && valid_i[idx] && (addr_i[idx] == rd_addr_i)) begin
        found  = 1'b1;
        data_o = data_i[idx];
      end
    end
    hit_o = found;
  end

endmodule

// File: rtl/regfile_wb_buffer.sv
// Writeback buffer in front of a 2R/1W regfile: queues writes, drains one per
// granted cycle, and forwards pending data to both read ports.
module regfile_wb_buffer
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_W     = RF_ADDR_W,
  parameter int unsigned DATA_W     = RF_DATA_W,
  parameter bit          DISCARD_R0 = 1'b1
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [DATA_W-1:0]          req_data,
  output logic                       WR,
  output logic [ADDR_W-1:0]          RW,
  output logic [DATA_W-1:0]          DW,
  input  logic                       wp_grant,
  input  logic [ADDR_W-1:0]          rd_addr_a,
  input  logic [ADDR_W-1:0]          rd_addr_b,
  output logic                       fwd_hit_a,
  output logic [DATA_W-1:0]          fwd_data_a,
  output logic                       fwd_hit_b,
  output logic [DATA_W-1:0]          fwd_data_b,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // Same layout as wb_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t              mem_q [DEPTH];
  ptr_t                head_q, head_d;
  ptr_t                tail_q, tail_d;
  cnt_t                count_q, count_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   rw_q, rw_d;
  logic [DATA_W-1:0]   dw_q, dw_d;

  logic                push_fire;
  logic                push_en;
  logic                pop;

  logic [DEPTH-1:0]             ent_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;
  logic [DEPTH-1:0][DATA_W-1:0] ent_data;

  assign req_ready = (count_q != cnt_t'(DEPTH));
  assign push_fire = req_valid & req_ready;
  assign push_en   = push_fire & ~(DISCARD_R0 && (req_addr == '0));
  assign pop       = wr_q & wp_grant;

  // Next pointers/count, and the head entry that will face the regfile next cycle.
  // WR/RW/DW are registered copies of that head, so they need the post-update
  // head: a push into an (effectively) empty FIFO bypasses storage here.
  always_comb begin
    head_d  = head_q + ptr_t'(pop);
    tail_d  = tail_q + ptr_t'(push_en);
    count_d = count_q + cnt_t'(push_en) - cnt_t'(pop);
    wr_d    = (count_d != '0);
    rw_d    = rw_q;
    dw_d    = dw_q;
    if (count_d != '0) begin
      if ((count_q - cnt_t'(pop)) == '0) begin
        rw_d = req_addr;
        dw_d = req_data;
      end else begin
        rw_d = mem_q[head_d].addr;
        dw_d = mem_q[head_d].data;
      end
    end
  end

  // FIFO storage, pointers, count and registered write-port outputs.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      wr_q    <= 1'b0;
      rw_q    <= '0;
      dw_q    <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      wr_q    <= wr_d;
      rw_q    <= rw_d;
      dw_q    <= dw_d;
      if (pop) mem_q[head_q].valid <= 1'b0;
      if (push_en) begin
        mem_q[tail_q].valid <= 1'b1;
        mem_q[tail_q].addr  <= req_addr;
        mem_q[tail_q].data  <= req_data;
      end
    end
  end

  // Flatten storage for the forwarding searchers.
  always_comb begin
    ent_valid = '0;
    ent_addr  = '0;
    ent_data  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ent_valid[i] = mem_q[i].valid;
      ent_addr[i]  = mem_q[i].addr;
      ent_data[i]  = mem_q[i].data;
    end
  end

  regfile_fwd_match #(
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .PTR_W      (PTR_W),
    .DISCARD_R0 (DISCARD_R0)
  ) u_fwd_a (
    .valid_i   (ent_valid),
    .addr_i    (ent_addr),
    .data_i    (ent_data),
    .tail_i    (tail_q),
    .rd_addr_i (rd_addr_a),
    .hit_o     (fwd_hit_a),
    .data_o    (fwd_data_a)
  );

  regfile_fwd_match #(
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .PTR_W      (PTR_W),
    .DISCARD_R0 (DISCARD_R0)
  ) u_fwd_b (
    .valid_i   (ent_valid),
    .addr_i    (ent_addr),
    .data_i    (ent_data),
    .tail_i    (tail_q),
    .rd_addr_i (rd_addr_b),
    .hit_o     (fwd_hit_b),
    .data_o    (fwd_data_b)
  );

  assign WR    = wr_q;
  assign RW    = rw_q;
  assign DW    = dw_q;
  assign count = count_q;

endmodule
